// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - circular pipeline trace recorder with trigger, post-trigger capture and stream drain
// Optional per-record 16-bit cycle timestamp is enabled by defining TRACE_TIMESTAMP_EN.
module pipe_trace_buffer #(
    parameter int DEPTH        = 16,
    parameter int POST_TRIG    = 4,
    parameter int XLEN         = 16,
    parameter int REG_AW       = 3,
    parameter int TRIG_ON_HALT = 1,
`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_W        = 16,
`else
    localparam int TS_W        = 0,
`endif
    localparam int REC_W       = 4*XLEN + REG_AW + 3 + TS_W,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic              trig_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   instr_i,
    input  logic [XLEN-1:0]   alu_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_we_i,
    input  logic              stall_i,
    input  logic              halt_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [REC_W-1:0]  out_data_o,
    output logic [1:0]        state_o,
    output logic [AW:0]       fill_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_POST  = 2'b10,
        S_DRAIN = 2'b11
    } state_t;

    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE       = (AW+1)'(1);
    localparam logic [AW-1:0] POST_LAST = AW'(POST_TRIG - 1);

    state_t           state;
    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fill;
    logic [AW:0]      remaining;
    logic [AW-1:0]    post_cnt;
    logic             drain_init;
    logic [REC_W-1:0] rec;
    logic             trig_hit;
    logic             capture;
    logic             xfer;

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts <= '0;
        else        ts <= ts + 16'd1;
    end

    assign rec = {ts, wb_we_i, wb_rd_i, stall_i, halt_i, pc_i, instr_i, alu_i, wb_data_i};
`else
    assign rec = {wb_we_i, wb_rd_i, stall_i, halt_i, pc_i, instr_i, alu_i, wb_data_i};
`endif

    assign trig_hit = trig_i | ((TRIG_ON_HALT != 0) && halt_i);
    assign capture  = !abort_i && (state == S_ARMED || state == S_POST);
    assign xfer     = !abort_i && (state == S_DRAIN) && out_valid_o && out_ready_i;

    assign done_o     = xfer && (remaining == ONE);
    assign out_data_o = out_valid_o ? mem[rd_ptr] : '0;
    assign state_o    = state;
    assign fill_o     = fill;

    // Trace storage is intentionally left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr] <= rec;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            remaining   <= '0;
            post_cnt    <= '0;
            drain_init  <= 1'b0;
            out_valid_o <= 1'b0;
        end else if (abort_i) begin
            state       <= S_IDLE;
            drain_init  <= 1'b0;
            out_valid_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm_i) begin
                        state    <= S_ARMED;
                        wr_ptr   <= '0;
                        fill     <= '0;
                        post_cnt <= '0;
                    end
                end
                S_ARMED: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (fill != FULL) fill <= fill + 1'b1;
                    if (trig_hit) begin
                        post_cnt <= '0;
                        if (POST_TRIG == 0) begin
                            state      <= S_DRAIN;
                            drain_init <= 1'b1;
                        end else begin
                            state <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    post_cnt <= post_cnt + 1'b1;
                    if (fill != FULL) fill <= fill + 1'b1;
                    if (post_cnt == POST_LAST) begin
                        state      <= S_DRAIN;
                        drain_init <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    // First drain cycle locates the oldest record: wr_ptr once the ring has wrapped.
                    if (drain_init) begin
                        drain_init  <= 1'b0;
                        rd_ptr      <= (fill == FULL) ? wr_ptr : '0;
                        remaining   <= fill;
                        out_valid_o <= (fill != '0);
                    end else if (xfer) begin
                        rd_ptr    <= rd_ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == ONE) begin
                            out_valid_o <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end else if (!out_valid_o) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb/tb_pipe_trace_buffer.sv - self-checking bench for pipe_trace_buffer
module tb_pipe_trace_buffer;
    localparam int DEPTH     = 16;
    localparam int POST_TRIG = 4;
    localparam int XLEN      = 16;
    localparam int REG_AW    = 3;
`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_W = 16;
`else
    localparam int TS_W = 0;
`endif
    localparam int BASE_W = 4*XLEN + REG_AW + 3;
    localparam int REC_W  = BASE_W + TS_W;
    localparam int AW     = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic arm_i = 1'b0, abort_i = 1'b0, trig_i = 1'b0;
    logic [XLEN-1:0] pc_i = '0, instr_i = '0, alu_i = '0, wb_data_i = '0;
    logic [REG_AW-1:0] wb_rd_i = '0;
    logic wb_we_i = 1'b0, stall_i = 1'b0, halt_i = 1'b0, out_ready_i = 1'b0;

    logic             out_valid, done, out_valid_nh, done_nh;
    logic [REC_W-1:0] out_data, out_data_nh;
    logic [1:0]       state, state_nh;
    logic [AW:0]      fill, fill_nh;

    int checks = 0;
    int errors = 0;
    logic [BASE_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .XLEN(XLEN), .REG_AW(REG_AW), .TRIG_ON_HALT(1)) dut (
        .clk(clk), .reset(reset), .arm_i(arm_i), .abort_i(abort_i), .trig_i(trig_i),
        .pc_i(pc_i), .instr_i(instr_i), .alu_i(alu_i), .wb_data_i(wb_data_i), .wb_rd_i(wb_rd_i),
        .wb_we_i(wb_we_i), .stall_i(stall_i), .halt_i(halt_i), .out_valid_o(out_valid),
        .out_ready_i(out_ready_i), .out_data_o(out_data), .state_o(state), .fill_o(fill), .done_o(done));

    pipe_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .XLEN(XLEN), .REG_AW(REG_AW), .TRIG_ON_HALT(0)) dut_nh (
        .clk(clk), .reset(reset), .arm_i(arm_i), .abort_i(abort_i), .trig_i(trig_i),
        .pc_i(pc_i), .instr_i(instr_i), .alu_i(alu_i), .wb_data_i(wb_data_i), .wb_rd_i(wb_rd_i),
        .wb_we_i(wb_we_i), .stall_i(stall_i), .halt_i(halt_i), .out_valid_o(out_valid_nh),
        .out_ready_i(out_ready_i), .out_data_o(out_data_nh), .state_o(state_nh), .fill_o(fill_nh), .done_o(done_nh));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rec(input int i, input logic trig, input logic halt);
        pc_i      = XLEN'(i);
        instr_i   = XLEN'($urandom);
        alu_i     = XLEN'($urandom);
        wb_data_i = XLEN'($urandom);
        wb_rd_i   = REG_AW'($urandom_range(0, 7));
        wb_we_i   = 1'($urandom_range(0, 1));
        stall_i   = 1'($urandom_range(0, 1));
        trig_i    = trig;
        halt_i    = halt;
        exp_q.push_back({wb_we_i, wb_rd_i, stall_i, halt_i, pc_i, instr_i, alu_i, wb_data_i});
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1.., 2: random ready
    task automatic drain(input int mode);
        int n = exp_q.size();
        int first = (n > DEPTH) ? n - DEPTH : 0;
        int idx = first;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [REC_W-1:0] held = '0;
        logic [15:0] prev_ts = '0;
        while (idx < n && cyc < 400) begin
            case (mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = (cyc % 3 == 0);
                default: out_ready_i = 1'($urandom_range(0, 1));
            endcase
            #1;
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data[BASE_W-1:0], exp_q[idx]);
            if (stalled) chk("hold_stable", out_data, held);
`ifdef TRACE_TIMESTAMP_EN
            if (idx > first && !stalled) chk("ts_step", out_data[REC_W-1:BASE_W], prev_ts + 16'd1);
            prev_ts = out_data[REC_W-1:BASE_W];
`endif
            if (out_ready_i) begin
                chk("done_beat", done, (idx == n - 1));
                idx++;
                stalled = 1'b0;
            end else begin
                held = out_data;
                stalled = 1'b1;
            end
            cyc++;
            tick();
        end
        out_ready_i = 1'b0;
        chk("drain_count", idx, n);
        chk("after_drain_state", state, 2'b00);
        chk("after_drain_valid", out_valid, 0);
        chk("after_drain_fill", fill, (n > DEPTH) ? DEPTH : n);
    endtask

    task automatic capture_run(input int k, input logic by_halt, input int mode);
        int n = k + POST_TRIG + 1;
        exp_q.delete();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        chk("armed_state", state, 2'b01);
        for (int i = 0; i < n; i++) begin
            drive_rec(i, !by_halt && i == k, by_halt && i == k);
            tick();
            if (i == k) chk("post_state", state, 2'b10);
        end
        trig_i = 1'b0;
        halt_i = 1'b0;
        chk("drain_state", state, 2'b11);
        chk("valid_latency_lo", out_valid, 0);
        tick();
        chk("valid_latency_hi", out_valid, 1);
        chk("fill_at_drain", fill, (n > DEPTH) ? DEPTH : n);
        drain(mode);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_state", state, 2'b00);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_fill", fill, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        repeat (5) tick();

        capture_run(10, 1'b0, 0);
        capture_run(30, 1'b0, 0);
        capture_run(20, 1'b0, 1);

        capture_run(7, 1'b1, 0);
        chk("no_halt_trig_state", state_nh, 2'b01);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("nh_abort_state", state_nh, 2'b00);

        arm_i = 1'b1;
        abort_i = 1'b1;
        tick();
        arm_i = 1'b0;
        abort_i = 1'b0;
        chk("arm_abort_idle", state, 2'b00);

        for (int r = 0; r < 4; r++) capture_run($urandom_range(0, 40), 1'b0, 2);

        // abort while in POST
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_rec(i, i == 2, 1'b0);
            tick();
        end
        trig_i = 1'b0;
        chk("pre_abort_post", state, 2'b10);
        abort_i = 1'b1;
        #1;
        chk("abort_no_done", done, 0);
        tick();
        abort_i = 1'b0;
        chk("abort_state", state, 2'b00);
        chk("abort_valid", out_valid, 0);
        repeat (6) begin
            tick();
            chk("abort_quiet", out_valid, 0);
        end
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        chk("rearm_fill", fill, 0);
        chk("rearm_state", state, 2'b01);

        // asynchronous reset in the middle of a drain
        for (int i = 0; i < 5 + POST_TRIG + 1; i++) begin
            drive_rec(i, i == 5, 1'b0);
            tick();
        end
        trig_i = 1'b0;
        tick();
        out_ready_i = 1'b1;
        repeat (2) tick();
        chk("mid_drain_valid", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_data", out_data, 0);
        chk("async_rst_state", state, 2'b00);
        chk("async_rst_fill", fill, 0);
        chk("async_rst_done", done, 0);
        out_ready_i = 1'b0;
        tick();
        reset = 1'b1;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
